// File: rtl/rv_immgen_stage.sv
// -----------------------------------------------------------------------------
// rv_immgen_stage
//   Registered immediate-generation stage for the RV decode path. Each accepted
//   instruction is classified into a format, and its immediate is selected and
//   extended to XLEN. Results pass through a 2-entry skid buffer: an output
//   register plus one skid register. Because of the skid register, in_ready is
//   a registered signal. A saturating counter tracks accepted illegal opcodes.
//
// Optional feature (compile-time macro RV_IMMGEN_ZIMM_EN):
//   When defined, CSRRWI/CSRRSI/CSRRCI (opcode 1110011, funct3 101/110/111)
//   report fmt=6 (Z). Their immediate is the zero-extended zimm field
//   instr[19:15]. When not defined, these encodings decode as plain I-type.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  sideband tag width (normally the PC), passed through unchanged
//   CNT_W  illegal-opcode counter width
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   flush         drops the output and skid entries at the next edge
//   in_valid      instruction presented
//   in_ready      stage can accept (= !skid_valid)
//   in_instr      32-bit instruction word
//   in_tag        sideband tag
//   out_valid     result valid
//   out_ready     consumer accepts
//   out_imm       immediate, extended to XLEN
//   out_fmt       0=R 1=I 2=S 3=B 4=U 5=J 6=Z 7=illegal
//   out_instr     registered instruction copy
//   out_tag       registered tag
//   illegal_cnt   saturating count of accepted illegal opcodes
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer. Ready may depend only on registered state.
// -----------------------------------------------------------------------------
module rv_immgen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_Z   = 3'd6;
   localparam logic [2:0] FMT_ILL = 3'd7;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // ---------------------------------------------------------------------------
   // Combinational decode of the presented instruction
   // ---------------------------------------------------------------------------
   logic [2:0]        dec_fmt;
   logic [XLEN-1:0]   dec_imm;
   logic signed [31:0] imm32;

   always_comb begin
      dec_fmt = FMT_ILL;
      dec_imm = '0;
      imm32   = '0;

      // Compressed or otherwise non-32-bit encodings are never legal here.
      if (in_instr[1:0] == 2'b11) begin
         case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
            7'b1110011: begin
               dec_fmt = FMT_I;
`ifdef RV_IMMGEN_ZIMM_EN
               // CSR*I forms: funct3 = 101, 110, 111
               if (in_instr[14] && (in_instr[13:12] != 2'b00)) dec_fmt = FMT_Z;
`endif
            end
            7'b0011011: if (XLEN == 64) dec_fmt = FMT_I;
            7'b0100011: dec_fmt = FMT_S;
            7'b1100011: dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111: dec_fmt = FMT_J;
            7'b0110011: dec_fmt = FMT_R;
            7'b0111011: if (XLEN == 64) dec_fmt = FMT_R;
            default: dec_fmt = FMT_ILL;
         endcase
      end

      // Build a 32-bit signed immediate first. Widening it as a signed value
      // then replicates instr[31] into the upper half for XLEN=64.
      case (dec_fmt)
         FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: imm32 = {in_instr[31:12], 12'h000};
         FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      dec_imm = XLEN'(imm32);

`ifdef RV_IMMGEN_ZIMM_EN
      if (dec_fmt == FMT_Z) dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
`endif
   end

   // ---------------------------------------------------------------------------
   // Output register plus skid register
   // ---------------------------------------------------------------------------
   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   logic [2:0]       skid_fmt;
   logic [31:0]      skid_instr;
   logic [TAG_W-1:0] skid_tag;

   logic accept;

   assign in_ready = !skid_valid;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_imm     <= '0;
         out_fmt     <= FMT_R;
         out_instr   <= '0;
         out_tag     <= '0;
         skid_valid  <= 1'b0;
         skid_imm    <= '0;
         skid_fmt    <= FMT_R;
         skid_instr  <= '0;
         skid_tag    <= '0;
         illegal_cnt <= '0;
      end else begin
         // Counted at accept time, so flushed illegals are still counted.
         if (accept && (dec_fmt == FMT_ILL) && (illegal_cnt != CNT_MAX))
            illegal_cnt <= illegal_cnt + CNT_W'(1);

         if (flush) begin
            // Any same-cycle accept is discarded along with buffered entries.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
         end else if (!out_valid || out_ready) begin
            // The output slot frees up this edge. The skid entry is older, so it
            // goes first. It cannot collide with an accept because in_ready=0.
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_imm    <= skid_imm;
               out_fmt    <= skid_fmt;
               out_instr  <= skid_instr;
               out_tag    <= skid_tag;
               skid_valid <= 1'b0;
            end else if (accept) begin
               out_valid <= 1'b1;
               out_imm   <= dec_imm;
               out_fmt   <= dec_fmt;
               out_instr <= in_instr;
               out_tag   <= in_tag;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            // The output is stalled, so park the new result behind it.
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_instr <= in_instr;
            skid_tag   <= in_tag;
         end
      end
   end

endmodule

// File: tb/tb_rv_immgen_stage.sv
// -----------------------------------------------------------------------------
// tb_rv_immgen_stage
//   Bench for rv_immgen_stage. It uses one XLEN=32 / CNT_W=16 instance with a
//   scoreboard, and one XLEN=64 / CNT_W=2 instance that is checked directly.
//   Expectations for CSR*I depend on RV_IMMGEN_ZIMM_EN.
// -----------------------------------------------------------------------------
module tb_rv_immgen_stage;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT (XLEN=32) ----------------
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [31:0] out_instr;
   logic [31:0] out_tag;
   logic [15:0] illegal_cnt;

   rv_immgen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_instr(out_instr), .out_tag(out_tag), .illegal_cnt(illegal_cnt)
   );

   // ---------------- DUT (XLEN=64, CNT_W=2) ----------------
   logic        in_valid64 = 1'b0;
   logic        in_ready64;
   logic [31:0] in_instr64 = '0;
   logic        out_valid64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic [31:0] out_instr64;
   logic [31:0] out_tag64;
   logic [1:0]  illegal_cnt64;

   rv_immgen_stage #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut64 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_tag(32'h0000_0064),
      .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64), .out_fmt(out_fmt64),
      .out_instr(out_instr64), .out_tag(out_tag64), .illegal_cnt(illegal_cnt64)
   );

   // ---------------- scoreboard ----------------
   // Entry layout: {fmt[2:0], imm[31:0], instr[31:0], tag[31:0]}
   logic [98:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference decode for XLEN=32, built directly from the field layouts.
   function automatic logic [34:0] model32(input logic [31:0] i);
      logic [2:0]  f;
      logic [31:0] m;
      f = 3'd7;
      if (i[1:0] == 2'b11) begin
         case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: f = 3'd1;
            7'b1110011: begin
               f = 3'd1;
`ifdef RV_IMMGEN_ZIMM_EN
               if (i[14:12] == 3'b101 || i[14:12] == 3'b110 || i[14:12] == 3'b111) f = 3'd6;
`endif
            end
            7'b0100011: f = 3'd2;
            7'b1100011: f = 3'd3;
            7'b0110111, 7'b0010111: f = 3'd4;
            7'b1101111: f = 3'd5;
            7'b0110011: f = 3'd0;
            default: f = 3'd7;
         endcase
      end
      case (f)
         3'd1: m = {{20{i[31]}}, i[31:20]};
         3'd2: m = {{20{i[31]}}, i[31:25], i[11:7]};
         3'd3: m = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd4: m = {i[31:12], 12'h000};
         3'd5: m = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd6: m = {27'd0, i[19:15]};
         default: m = 32'd0;
      endcase
      return {f, m};
   endfunction

   // Monitor: compare every output transfer against the queue head.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {61'd0, out_fmt}, 64'd0 - 64'd1);
         end else begin
            logic [98:0] e;
            e = exp_q.pop_front();
            check("sb_fmt",   {61'd0, out_fmt}, {61'd0, e[98:96]});
            check("sb_imm",   {32'd0, out_imm}, {32'd0, e[95:64]});
            check("sb_instr", {32'd0, out_instr}, {32'd0, e[63:32]});
            check("sb_tag",   {32'd0, out_tag}, {32'd0, e[31:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present one instruction. The expected entry is pushed on the negedge
   // before the accepting edge. If the output is stalled, backpressure is
   // released so the accept can complete.
   task automatic send(input logic [31:0] instr, input logic [31:0] tag,
                       input logic [2:0] efmt, input logic [31:0] eimm);
      int budget;
      budget = 0;
      in_valid = 1'b1;
      in_instr = instr;
      in_tag   = tag;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         budget++;
         if (budget > 50) begin
            check("send_timeout", {63'd0, in_ready}, 64'd1);
            break;
         end
         if (!out_ready) begin
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      end
      if (in_ready === 1'b1) begin
         exp_q.push_back({efmt, eimm, instr, tag});
         if (efmt == 3'd7 && exp_cnt < 65535) exp_cnt++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [31:0] instr, input logic [31:0] tag);
      logic [34:0] m;
      m = model32(instr);
      send(instr, tag, m[34:32], m[31:0]);
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic send64(input logic [31:0] instr, input logic [2:0] efmt,
                         input logic [63:0] eimm, input string tag);
      in_valid64 = 1'b1;
      in_instr64 = instr;
      @(posedge clk);
      #1 in_valid64 = 1'b0;
      check({tag, "_valid"}, {63'd0, out_valid64}, 64'd1);
      check({tag, "_fmt"}, {61'd0, out_fmt64}, {61'd0, efmt});
      check({tag, "_imm"}, out_imm64, eimm);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   localparam logic [6:0] OPS [14] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111,
                                      7'b1110011, 7'b0011011, 7'b0100011, 7'b1100011,
                                      7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                                      7'b0111011, 7'b1111111};

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
      check("rst_out_imm",   {32'd0, out_imm}, 64'd0);
      check("rst_out_fmt",   {61'd0, out_fmt}, 64'd0);
      check("rst_out_instr", {32'd0, out_instr}, 64'd0);
      check("rst_out_tag",   {32'd0, out_tag}, 64'd0);
      check("rst_cnt",       {48'd0, illegal_cnt}, 64'd0);
      check("rst_cnt64",     {62'd0, illegal_cnt64}, 64'd0);

      // Single ADDI with 1-cycle latency
      out_ready = 1'b1;
      send(32'hFFF0_0093, 32'h0000_1000, 3'd1, 32'hFFFF_FFFF);
      check("addi_latency_valid", {63'd0, out_valid}, 64'd1);
      check("addi_tag", {32'd0, out_tag}, 64'h1000);
      drain();

      // Format sweep
      send(32'hFE11_2E23, 32'h0000_1004, 3'd2, 32'hFFFF_FFFC);
      send(32'hFE00_0EE3, 32'h0000_1008, 3'd3, 32'hFFFF_FFFC);
      send(32'h1234_50B7, 32'h0000_100C, 3'd4, 32'h1234_5000);
      send(32'hFF9F_F0EF, 32'h0000_1010, 3'd5, 32'hFFFF_FFF8);
      send(32'h0000_0033, 32'h0000_1014, 3'd0, 32'h0);
      send(32'h0010_009B, 32'h0000_1018, 3'd7, 32'h0);     // ADDIW is illegal at XLEN=32
`ifdef RV_IMMGEN_ZIMM_EN
      send(32'h3401_D073, 32'h0000_101C, 3'd6, 32'h3);
`else
      send(32'h3401_D073, 32'h0000_101C, 3'd1, 32'h340);
`endif
      drain();

      // Backpressure: a, b accepted; c held off until release
      out_ready = 1'b0;
      send(32'h0010_0093, 32'h0000_2000, 3'd1, 32'h1);
      send(32'h0020_0113, 32'h0000_2004, 3'd1, 32'h2);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b1;
      in_instr = 32'h0030_0193;
      in_tag   = 32'h0000_2008;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
         check("bp_hold_instr", {32'd0, out_instr}, 64'h0010_0093);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(32'h0030_0193, 32'h0000_2008, 3'd1, 32'h3);
      drain();

      // Illegal counting
      send(32'h0000_007F, 32'h0000_3000, 3'd7, 32'h0);
      check("ill_cnt_1", {48'd0, illegal_cnt}, 64'(exp_cnt));
      send(32'hFFFF_FF10, 32'h0000_3004, 3'd7, 32'h0);
      check("ill_cnt_2", {48'd0, illegal_cnt}, 64'(exp_cnt));
      drain();

      // Flush with output and skid both full
      out_ready = 1'b0;
      send(32'h0000_007F, 32'h0000_4000, 3'd7, 32'h0);
      send(32'h0000_00FF, 32'h0000_4004, 3'd7, 32'h0);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      exp_q.delete();
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_in_ready",  {63'd0, in_ready}, 64'd1);
      check("flush_cnt",       {48'd0, illegal_cnt}, 64'(exp_cnt));

      // Flush with a same-cycle accept: the entry is discarded but still counted
      send(32'h0040_0213, 32'h0000_4008, 3'd1, 32'h4);
      in_valid = 1'b1;
      in_instr = 32'h0000_0001;
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      exp_cnt++;
      check("flush_acc_valid", {63'd0, out_valid}, 64'd0);
      check("flush_acc_cnt",   {48'd0, illegal_cnt}, 64'(exp_cnt));

      // Random stream with random backpressure
      for (int n = 0; n < 30; n++) begin
         logic [31:0] r;
         r = $urandom();
         r[6:0] = OPS[$urandom_range(0, 13)];
         if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(0, 2));
         out_ready = ($urandom_range(0, 2) != 0);
         send_model(r, 32'h0000_5000 + 32'(n * 4));
      end
      drain();
      check("rand_cnt", {48'd0, illegal_cnt}, 64'(exp_cnt));

      // rst together with flush while buffered
      out_ready = 1'b0;
      send(32'h1234_50B7, 32'h0000_6000, 3'd4, 32'h1234_5000);
      rst = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      flush = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      check("rf_out_valid", {63'd0, out_valid}, 64'd0);
      check("rf_in_ready",  {63'd0, in_ready}, 64'd1);
      check("rf_out_imm",   {32'd0, out_imm}, 64'd0);
      check("rf_out_fmt",   {61'd0, out_fmt}, 64'd0);
      check("rf_out_instr", {32'd0, out_instr}, 64'd0);
      check("rf_out_tag",   {32'd0, out_tag}, 64'd0);
      check("rf_cnt",       {48'd0, illegal_cnt}, 64'd0);

      // XLEN=64 instance
      send64(32'h8000_00B7, 3'd4, 64'hFFFF_FFFF_8000_0000, "x64_lui");
      send64(32'h0010_009B, 3'd1, 64'h1, "x64_addiw");
      send64(32'h0000_003B, 3'd0, 64'h0, "x64_addw");
`ifdef RV_IMMGEN_ZIMM_EN
      send64(32'h3401_D073, 3'd6, 64'h3, "x64_csrrwi");
`else
      send64(32'h3401_D073, 3'd1, 64'h340, "x64_csrrwi");
`endif
      send64(32'hFE00_0EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, "x64_beq");
      for (int k = 0; k < 5; k++) send64(32'h0000_007F, 3'd7, 64'h0, "x64_ill");
      check("x64_cnt_sat", {62'd0, illegal_cnt64}, 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_immgen_stage.md
Name: rv_immgen_stage

Overview:
- Registered, parametrised immediate-generation pipeline stage for the RV core decode path.
- Accepts one instruction word per cycle with a tag (PC) over a valid/ready handshake.
- Classifies the opcode into an instruction format, selects the matching immediate and sign-extends it to XLEN.
- Buffers results through a 2-entry skid (output register plus skid register), so in_ready is a registered signal. Also keeps a saturating count of illegal opcodes.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (normally the PC), passed through unchanged.
- CNT_W, 16, width of the illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  drops all buffered entries; takes effect at the next edge
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept; equals !skid_valid
- in_instr  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  selected immediate, sign-extended
- out_fmt  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z, 7=illegal
- out_instr  out  32  registered copy of the instruction
- out_tag  out  TAG_W  registered tag
- illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes

Behaviour:
- Reset (synchronous): out_valid=0, skid_valid=0 (so in_ready=1), out_imm=0, out_fmt=0, out_instr=0, out_tag=0, illegal_cnt=0.
- Opcode decode uses instr[6:0]:
  - I: 0000011, 0010011, 1100111, 0001111, 1110011. 0011011 is I only when XLEN=64, otherwise illegal.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011. 0111011 is R only when XLEN=64, otherwise illegal.
  - Any other opcode: fmt=7.
  - Also fmt=7 whenever instr[1:0]!=2'b11.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'h000}; for XLEN=64, bits 63:32 replicate instr[31].
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: imm=0.
- Handshake:
  - Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - Latency is exactly 1 cycle from accept to out_valid when the output register is free.
- Skid operation:
  - Accept while output is empty or transferring: the decoded result loads the output register.
  - Accept while output is valid and out_ready=0: the result loads the skid register and skid_valid is set.
  - skid_valid=1 and out_ready=1: the skid entry moves into the output register. A simultaneous new accept cannot occur because in_ready=0.
  - Ordering is strict FIFO. No entry is ever dropped or duplicated. out_* fields are stable while out_valid=1 and out_ready=0.
- Flush: out_valid<=0 and skid_valid<=0, and any same-cycle input accept is discarded. illegal_cnt is unaffected. rst has priority over flush.
- illegal_cnt:
  - Increments by 1 per accepted instruction with fmt=7.
  - Saturates at 2^CNT_W-1.
  - Counts at accept time, including instructions later flushed.
- Data registers may hold stale values when their valid bit is 0; only out_valid qualifies the output.

Optional Feature:
- Macro: RV_IMMGEN_ZIMM_EN.
- Defined: SYSTEM instructions (opcode 1110011) with funct3 in {101, 110, 111} (CSRRWI, CSRRSI, CSRRCI) report fmt=6. Their imm is the zero-extended zimm = {(XLEN-5) zeros, instr[19:15]}.
- Not defined: those encodings report fmt=1 with the sign-extended I immediate, and fmt code 6 is never produced.

Test Plan:
- Reset then single ADDI: instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=1, imm=0xFFFFFFFF, out_tag equals input tag.
- Format sweep at XLEN=32:
  - SW 0xFE112E23 -> fmt=2, imm=0xFFFFFFFC.
  - BEQ 0xFE000EE3 -> fmt=3, imm=0xFFFFFFFC.
  - LUI 0x123450B7 -> fmt=4, imm=0x12345000.
  - JAL 0xFF9FF0EF -> fmt=5, imm=0xFFFFFFF8.
- Backpressure: hold out_ready=0 and stream 3 instructions back-to-back -> first two accepted, in_ready=0 from the cycle after the second accept. Release out_ready -> outputs appear in order with no loss or duplication.
- Illegal counting: feed opcode 0x7F and instr[1:0]=00 words -> fmt=7, imm=0, illegal_cnt increments. With CNT_W=2, five illegals -> illegal_cnt=3.
- Flush while output and skid are both full -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged. rst asserted together with flush -> all outputs return to reset values.
- XLEN=64 with RV_IMMGEN_ZIMM_EN defined:
  - LUI 0x800000B7 -> imm=0xFFFFFFFF80000000.
  - ADDIW 0x0010009B -> fmt=1.
  - CSRRWI 0x3401D073 -> fmt=6, imm=0x3.
  - Same CSRRWI with the macro undefined -> fmt=1, imm=0x340.
